// File: rtl/patp_ctrl_seq_pkg.sv
// Shared definitions for the PATP control sequencer: opcodes, ALU operations
// and the 4-bit state encoding.
package patp_ctrl_seq_pkg;

  // Instruction opcodes, taken from IR[7:5]
  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_JZ    = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  // ALU operation select; 2'b11 is never produced
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_F_MAR = 4'd1,
    S_F_RD  = 4'd2,
    S_F_IR  = 4'd3,
    S_DEC   = 4'd4,
    S_X_MAR = 4'd5,
    S_X_RD  = 4'd6,
    S_X_ACC = 4'd7,
    S_X_WR  = 4'd8,
    S_JMP   = 4'd9,
    S_FAULT = 4'd10
  } state_t;

  // States that hold a memory request open until mem_ack
  function automatic logic is_wait(input state_t s);
    return (s == S_F_RD) || (s == S_X_RD) || (s == S_X_WR);
  endfunction

endpackage

// File: rtl/patp_ctrl_seq.sv
// Fetch/decode/execute sequencer for the PATP core. Drives the datapath load
// strobes and the memory req/ack handshake, and faults on a memory timeout.
module patp_ctrl_seq
  import patp_ctrl_seq_pkg::*;
#(
  parameter int OP_W       = 3,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [OP_W-1:0] ir_opcode,
  input  logic            acc_zero,
  input  logic            mem_ack,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            clk_mar,
  output logic            mar_sel,
  output logic            clk_mbr,
  output logic            clk_ir,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            clk_acc,
  output logic [1:0]      alu_op,
  output logic            halted,
  output logic            fault
);

  state_t           state_reg;
  state_t           state_next;
  logic [2:0]       op_reg;
  logic [2:0]       op_in;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             in_wait;
  logic             timed_out;

  assign op_in   = 3'(ir_opcode);
  assign in_wait = is_wait(state_reg);

  // A request times out in the cycle the counter sits at the limit without an
  // ack; an ack in that same cycle takes priority. A limit of 0 disables it.
  assign timed_out = (WAIT_LIMIT != 0) && !mem_ack &&
                     (wait_cnt_reg == CNT_W'(WAIT_LIMIT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the opcode at decode so execute-phase decisions do not depend on
  // IR staying stable after S_DEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg <= OP_NOP;
    end else if (state_reg == S_DEC) begin
      op_reg <= op_in;
    end
  end

  // Wait counter: zero outside wait states, so every wait state is entered
  // with a cleared count; saturates rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (in_wait && !mem_ack) begin
      if (wait_cnt_reg != '1) begin
        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      end
    end else begin
      wait_cnt_reg <= '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (run) state_next = S_F_MAR;
      S_F_MAR: state_next = S_F_RD;
      S_F_RD: begin
        if (mem_ack)        state_next = S_F_IR;
        else if (timed_out) state_next = S_FAULT;
      end
      S_F_IR:  state_next = S_DEC;
      S_DEC: begin
        case (op_in)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_next = S_X_MAR;
          OP_JMP:  state_next = S_JMP;
          OP_JZ:   state_next = acc_zero ? S_JMP : S_F_MAR;
          OP_NOP:  state_next = S_F_MAR;
          OP_HALT: state_next = S_IDLE;
          default: state_next = S_F_MAR;
        endcase
      end
      S_X_MAR: state_next = (op_reg == OP_STORE) ? S_X_WR : S_X_RD;
      S_X_RD: begin
        if (mem_ack)        state_next = S_X_ACC;
        else if (timed_out) state_next = S_FAULT;
      end
      S_X_ACC: state_next = S_F_MAR;
      S_X_WR: begin
        if (mem_ack)        state_next = S_F_MAR;
        else if (timed_out) state_next = S_FAULT;
      end
      S_JMP:   state_next = S_F_MAR;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode. The MBR capture and PC increment inside a read wait state
  // are qualified by mem_ack so they fire exactly once, on the data cycle.
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    clk_mar = 1'b0;
    mar_sel = 1'b0;
    clk_mbr = 1'b0;
    clk_ir  = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    clk_acc = 1'b0;
    alu_op  = ALU_PASS;
    halted  = 1'b0;
    fault   = 1'b0;
    case (state_reg)
      S_IDLE:  halted = 1'b1;
      S_F_MAR: clk_mar = 1'b1;
      S_F_RD: begin
        mem_rd  = 1'b1;
        clk_mbr = mem_ack;
        pc_inc  = mem_ack;
      end
      S_F_IR:  clk_ir = 1'b1;
      S_X_MAR: begin
        clk_mar = 1'b1;
        mar_sel = 1'b1;
      end
      S_X_RD: begin
        mem_rd  = 1'b1;
        clk_mbr = mem_ack;
      end
      S_X_ACC: begin
        clk_acc = 1'b1;
        case (op_reg)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          default: alu_op = ALU_PASS;
        endcase
      end
      S_X_WR:  mem_wr = 1'b1;
      S_JMP:   pc_load = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule
